// File: rtl/current_switch_ctrl_if.sv
// Config handshake bundle for current_switch_ctrl: a period/on-time pair offered with valid/ready.
interface current_switch_ctrl_if #(
   parameter int unsigned CNT_W = 16
) ();
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CNT_W-1:0] cfg_period;
   logic [CNT_W-1:0] cfg_on;

   modport master (output cfg_valid, output cfg_period, output cfg_on, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_period, input cfg_on, output cfg_ready);
endinterface

// File: rtl/current_switch_ctrl.sv
// PWM sequencer for the current_switch ctrl pin: programmable period/on-time,
// double-buffered config applied at period boundaries, graceful enable/disable.
module current_switch_ctrl #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DEF_PERIOD = 4,
   parameter int unsigned DEF_ON     = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   current_switch_ctrl_if.slave cfg,
   output logic                 ctrl,
   output logic                 period_start,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] on_q, on_d;
   logic [CNT_W-1:0] shadow_period_q, shadow_period_d;
   logic [CNT_W-1:0] shadow_on_q, shadow_on_d;
   logic             pending_q, pending_d;
   logic             ready_q;
   logic             accept, wrap, load;
   logic             ctrl_d, period_start_d, busy_d, ready_d;

   assign cfg.cfg_ready = ready_q;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         period_q        <= CNT_W'(DEF_PERIOD);
         on_q            <= CNT_W'(DEF_ON);
         shadow_period_q <= CNT_W'(DEF_PERIOD);
         shadow_on_q     <= CNT_W'(DEF_ON);
         pending_q       <= 1'b0;
         ready_q         <= 1'b1;
         ctrl            <= 1'b0;
         period_start    <= 1'b0;
         busy            <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         period_q        <= period_d;
         on_q            <= on_d;
         shadow_period_q <= shadow_period_d;
         shadow_on_q     <= shadow_on_d;
         pending_q       <= pending_d;
         ready_q         <= ready_d;
         ctrl            <= ctrl_d;
         period_start    <= period_start_d;
         busy            <= busy_d;
      end
   end

   // Next state, counter and config double-buffer
   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      period_d        = period_q;
      on_d            = on_q;
      shadow_period_d = shadow_period_q;
      shadow_on_d     = shadow_on_q;
      pending_d       = pending_q;

      accept = cfg.cfg_valid && !pending_q;
      // period_q is always >= 2, so the subtraction cannot underflow
      wrap   = (cnt_q == (period_q - CNT_W'(1)));
      load   = pending_q && ((state_q == IDLE) || wrap);

      // accept and load are exclusive: accept needs pending clear, load needs it set
      if (load) begin
         period_d  = shadow_period_q;
         on_d      = shadow_on_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         shadow_period_d = (cfg.cfg_period < CNT_W'(2)) ? CNT_W'(2) : cfg.cfg_period;
         shadow_on_d     = cfg.cfg_on;
         pending_d       = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en) state_d = RUN;
         end
         RUN: begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (!en) state_d = DRAIN;
         end
         DRAIN: begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (en) begin
               state_d = RUN;
            end else if (wrap) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Registered-output decode from next-cycle values so ctrl aligns with cnt
   always_comb begin
      busy_d         = (state_d != IDLE);
      ctrl_d         = busy_d && (cnt_d < on_d);
      period_start_d = busy_d && (cnt_d == '0);
      ready_d        = !pending_d;
   end

endmodule

// File: doc/current_switch_ctrl.md
Name: current_switch_ctrl

Overview:
- Digital PWM sequencer that drives the `ctrl` input of `current_switch` in emulation builds; it replaces the free-running fixed-duty `PWM` testbench source.
- Generates a glitch-free registered `ctrl` waveform with a programmable period and on-time, counted in `clk` cycles.
- New period/on-time values arrive over a valid/ready handshake and are double-buffered: they take effect only at a period boundary.
- Enable/disable is graceful: a disable request always completes the current period before `ctrl` parks low.

Parameters:
- CNT_W, 16, width of the period/on-time counters and config fields.
- DEF_PERIOD, 4, active period after reset, in cycles; must be ≥ 2.
- DEF_ON, 2, active on-time after reset, in cycles.

Ports:
- clk  input  1  system/emulator clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  level; high requests switching, low requests stop after the current period.
- cfg_valid  input  1  config offer.
- cfg_ready  output  1  config slot free.
- cfg_period  input  CNT_W  requested period, in cycles.
- cfg_on  input  CNT_W  requested on-time, in cycles.
- ctrl  output  1  switch control to `current_switch`; registered.
- period_start  output  1  one-cycle pulse on the first cycle of each period.
- busy  output  1  high in RUN or DRAIN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cnt=0, period_act=DEF_PERIOD, on_act=DEF_ON, pending=0.
  - ctrl=0, period_start=0, busy=0, cfg_ready=1.
- Config handshake:
  - Accept when cfg_valid && cfg_ready. The accepted values are latched into a shadow register and pending is set.
  - cfg_ready = !pending.
  - Loading: in IDLE the shadow loads into period_act/on_act on the next edge. In RUN/DRAIN it loads on the wrap edge (cnt == period_act-1). pending clears on load.
  - If an accept and a load occur on the same edge, the load uses the previous shadow and the new value becomes pending. This cannot occur while pending=1, because cfg_ready=0.
  - Period clamp: cfg_period < 2 is stored as 2.
  - on_act ≥ period_act gives ctrl constantly high while running. on_act = 0 gives ctrl constantly low while running.
- States:
  - IDLE: cnt held at 0, ctrl=0.
    - en=1 → RUN; the first active cycle follows one edge later with cnt=0.
  - RUN: cnt increments each edge and wraps from period_act-1 to 0.
    - en=0 observed at any cycle → DRAIN; cnt keeps counting.
  - DRAIN: identical counting to RUN.
    - At the wrap edge → IDLE (ctrl=0, cnt=0).
    - en=1 seen before the wrap → back to RUN with no interruption of the waveform.
- Output timing:
  - ctrl is the registered value of (next_state ∈ {RUN, DRAIN} && next_cnt < next_on_act).
  - It therefore aligns exactly with cnt and has zero combinational path to the pins.
  - period_start is the registered value of (next_state ∈ {RUN, DRAIN} && next_cnt == 0).
  - busy is the registered value of (next_state != IDLE).
- Latency: en rising at edge k (IDLE) gives ctrl/period_start/busy high after edge k+1 (ctrl only when on_act > 0).
- Config loaded at a wrap takes effect on the very cycle cnt=0 of the new period.
- Reset asserted mid-period: all outputs go to reset values immediately, without waiting for a clock edge.
- Counter arithmetic: unsigned, CNT_W bits. The maximum period is 2^CNT_W-1, and the wrap compare never overflows.

Test Plan:
- Reset, en=1, default config (period 4, on 2): ctrl = 1,1,0,0 repeating from the cycle after en. period_start is high on every 4th cycle, aligned with the first ctrl=1. busy=1 throughout.
- While running period 4/on 2, offer cfg (period 6, on 1) at cnt=1:
  - cfg_ready drops the next cycle.
  - The current period finishes as 1,1,0,0, then 1,0,0,0,0,0 repeats.
  - cfg_ready returns high at that boundary.
- Drop en at cnt=1 of period 4/on 2: the waveform completes 0,0 for cnt 2–3, then ctrl=0 and busy=0 from the next cycle. Re-raising en at cnt=2 instead keeps the waveform continuous.
- Boundary configs:
  - cfg_on=0 gives ctrl stuck at 0 while period_start still pulses.
  - cfg_on=9, period 5 gives ctrl stuck at 1.
  - cfg_period=1 is clamped to 2, giving period_start every 2 cycles.
- Back-to-back cfg_valid held high with two different values: the first is accepted and the second is stalled (cfg_ready=0) until the boundary, then accepted. Each value governs exactly the period it was loaded for.
- Assert rst_n=0 mid-on-time: ctrl, busy and period_start fall without waiting for a clk edge. After release with en=1, the sequence restarts with DEF_PERIOD/DEF_ON and any pending config is discarded.
